imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction memory address width (depth = 2**ADDR_W words).
REQ-002 Parameter DATA_W, default 16, instruction word width (4-bit opcode, rs, rt, rd).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  one-cycle pulse requesting a new program load.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_ready  output  1  loader can accept a word this cycle.
REQ-008 s_data  input  DATA_W  instruction word.
REQ-009 s_last  input  1  qualifies the final word of the program.
REQ-010 imem_we  output  1  instruction memory write enable.
REQ-011 imem_addr  output  ADDR_W  instruction memory write address.
REQ-012 imem_wdata  output  DATA_W  instruction memory write data.
REQ-013 cpu_hold  output  1  1 = keep the CPU pipeline in reset/stalled.
REQ-014 done  output  1  program loaded, memory padded, CPU released.
REQ-015 err  output  1  program overflowed memory depth.
REQ-016 word_count  output  ADDR_W+1  number of program words accepted.
REQ-017 checksum  output  DATA_W  running XOR of all accepted words.

Function
REQ-018 FSM states: IDLE, LOAD, FILL, RUN, ERR.
REQ-019 IDLE: s_ready=0, cpu_hold=1; start -> LOAD, clear word_count, checksum, write pointer.
REQ-020 LOAD: s_ready=1; handshake = s_valid & s_ready; no handshake, no state change.
REQ-021 Each handshake: next cycle imem_we=1, imem_addr=pointer, imem_wdata=s_data (latency 1); pointer+1, word_count+1, checksum ^= s_data.
REQ-022 Handshake with s_last at pointer < 2**ADDR_W-1 -> FILL; at pointer = 2**ADDR_W-1 -> RUN directly.
REQ-023 Handshake without s_last at pointer = 2**ADDR_W-1 -> ERR (last word still written).
REQ-024 FILL: s_ready=0; one write per cycle of 16'h0000 (NOP) at successive addresses up to 2**ADDR_W-1 inclusive, then -> RUN.
REQ-025 RUN: cpu_hold=0, done=1, s_ready=0; cpu_hold falls the cycle after the final memory write.
REQ-026 ERR: cpu_hold=1, err=1, s_ready=0; start -> LOAD (err cleared).
REQ-027 start in RUN -> LOAD with cpu_hold=1 and done=0 the next cycle; start in LOAD or FILL is ignored.
REQ-028 imem_we=0 in every cycle without a pending write; word_count and checksum hold in RUN/ERR.
REQ-029 Pointer never wraps; word_count saturates at 2**ADDR_W.

Reset
REQ-030 reset=0 at any clock edge, including mid-LOAD or mid-FILL: state IDLE, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0, word_count=0, checksum=0.
REQ-031 A write pending on the reset edge is dropped.

Structure
REQ-032 FSM state encoding, DATA_W, and NOP constant 16'h0000 belong in the shared cpu package.
REQ-033 Single flat module; no sub-module.

Verification
REQ-034 ADDR_W=4; start; words 0x1123,0x2345,0x4567,0x6789 (last on 4th) -> writes at addr 0-3, zeros at 4-15, then cpu_hold=0, done=1, word_count=4, checksum=0x1088.
REQ-035 ADDR_W=4; 16 words, s_last on 16th -> no FILL cycles, RUN the cycle after the addr-15 write.
REQ-036 ADDR_W=4; 16 words, no s_last -> err=1, cpu_hold=1, s_ready=0, word_count=16.
REQ-037 s_valid toggled 1,0,0,1,... over a 4-word program -> exactly 4 writes at consecutive addresses, no gaps in addresses.
REQ-038 reset=0 after the 2nd write in LOAD -> all outputs at reset values next cycle; new start loads correctly from addr 0.
REQ-039 start while in RUN -> cpu_hold=1, done=0 next cycle; second program overwrites from addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared cpu constants and loader state encoding
package imem_loader_pkg;

    localparam int CPU_DATA_W = 16;

    localparam logic [CPU_DATA_W-1:0] NOP_WORD = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FILL = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a program into instruction memory, NOP-pads it, then releases the CPU
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_csum;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_hold;
    logic              r_done;
    logic              r_err;

    logic w_hs;
    logic w_restart;

    assign w_hs      = s_valid & (r_state == ST_LOAD);
    assign w_restart = start & ((r_state == ST_IDLE) | (r_state == ST_RUN) | (r_state == ST_ERR));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_csum  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_restart) begin
                r_state <= ST_LOAD;
                r_ptr   <= '0;
                r_count <= '0;
                r_csum  <= '0;
                r_hold  <= 1'b1;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_hs) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_ptr;
                            r_wdata <= s_data;
                            r_csum  <= r_csum ^ s_data;
                            if (r_count != CNT_MAX) begin
                                r_count <= r_count + CNT_ONE;
                            end
                            // Pointer parks at the top address; the word there is still written.
                            if (r_ptr == PTR_MAX) begin
                                if (s_last) begin
                                    r_state <= ST_RUN;
                                end else begin
                                    r_state <= ST_ERR;
                                    r_err   <= 1'b1;
                                end
                            end else begin
                                r_ptr <= r_ptr + PTR_ONE;
                                if (s_last) begin
                                    r_state <= ST_FILL;
                                end
                            end
                        end
                    end
                    ST_FILL: begin
                        r_we    <= 1'b1;
                        r_addr  <= r_ptr;
                        r_wdata <= DATA_W'(NOP_WORD);
                        if (r_ptr == PTR_MAX) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_ptr <= r_ptr + PTR_ONE;
                        end
                    end
                    ST_RUN: begin
                        // First RUN cycle carries the final write; release the CPU one cycle later.
                        r_hold <= 1'b0;
                        r_done <= 1'b1;
                    end
                    ST_IDLE, ST_ERR: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign s_ready    = (r_state == ST_LOAD);
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_count;
    assign checksum   = r_csum;

endmodule
